// File: rtl/cfi_shadow_stack_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ==== cfi_shadow_stack_stage : commit-side CFI event queue + shadow-stack return checker (rev 1.0)
// ==== Optional `CFI_SS_WRAP_EN: circular stack with a saturating discard counter instead of overflow faults.
module cfi_shadow_stack_stage #(
  parameter int NR_PORTS    = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int STACK_DEPTH = 16,
  parameter int XLEN        = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NR_PORTS-1:0]           log_valid_i,
  input  logic [NR_PORTS-1:0][1:0]      log_kind_i,
  input  logic [NR_PORTS-1:0][XLEN-1:0] log_pc_i,
  input  logic [NR_PORTS-1:0][XLEN-1:0] log_target_i,
  input  logic [NR_PORTS-1:0]           log_rvc_i,
  output logic                          halt_o,
  output logic                          fault_valid_o,
  output logic [1:0]                    fault_cause_o,
  output logic [XLEN-1:0]               fault_pc_o,
  input  logic                          fault_ack_i,
  output logic [$clog2(STACK_DEPTH):0]  stack_usage_o
);
  localparam int QPW = $clog2(QUEUE_DEPTH);
  localparam int QCW = QPW + 1;
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int SCW = SPW + 1;
  localparam logic [QCW-1:0] Q_ONE    = QCW'(1);
  localparam logic [QCW-1:0] Q_FULL   = QCW'(QUEUE_DEPTH);
  localparam logic [QCW-1:0] Q_HALT   = QCW'(QUEUE_DEPTH - NR_PORTS);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
  localparam logic [SCW-1:0] SC_ONE   = SCW'(1);
  localparam logic [SCW-1:0] STK_FULL = SCW'(STACK_DEPTH);
  localparam logic [1:0] CAUSE_OVERRUN   = 2'b00;
  localparam logic [1:0] CAUSE_MISMATCH  = 2'b01;
  localparam logic [1:0] CAUSE_UNDERFLOW = 2'b11;
`ifndef CFI_SS_WRAP_EN
  localparam logic [1:0] CAUSE_OVERFLOW  = 2'b10;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_FAULT = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic [QCW-1:0]                 count_q, count_d;
  logic [QPW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SPW-1:0]                 sp_q, sp_d;
  logic [SCW-1:0]                 usage_q, usage_d;
  logic                           fault_valid_q, fault_valid_d;
  logic [1:0]                     fault_cause_q, fault_cause_d;
  logic [XLEN-1:0]                fault_pc_q, fault_pc_d;
`ifdef CFI_SS_WRAP_EN
  logic [SCW-1:0]                 disc_q, disc_d;
`endif

  logic                           q_ret_q [QUEUE_DEPTH];
  logic [XLEN-1:0]                q_pc_q  [QUEUE_DEPTH];
  logic [XLEN-1:0]                q_tgt_q [QUEUE_DEPTH];
  logic                           q_rvc_q [QUEUE_DEPTH];
  logic [XLEN-1:0]                stack_q [STACK_DEPTH];

  logic [QCW-1:0]                 q_free, n_req, n_acc;
  logic [NR_PORTS-1:0]            q_we;
  logic [NR_PORTS-1:0][QPW-1:0]   q_waddr;
  logic                           q_overrun, q_pop, stk_we, chk_fault;
  logic [1:0]                     chk_cause;
  logic [XLEN-1:0]                ret_addr, stack_top;

  assign q_free    = Q_FULL - count_q;
  assign ret_addr  = q_pc_q[rptr_q] + (q_rvc_q[rptr_q] ? XLEN'(2) : XLEN'(4));
  assign stack_top = stack_q[sp_q - SP_ONE];

  // Calls/returns are packed in port order; anything past the free space is dropped.
  always_comb begin
    q_we    = '0;
    q_waddr = '0;
    n_req   = '0;
    n_acc   = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (log_valid_i[p] && log_kind_i[p][1]) begin
        if (n_req < q_free) begin
          q_we[p]    = 1'b1;
          q_waddr[p] = wptr_q + n_req[QPW-1:0];
          n_acc      = n_acc + Q_ONE;
        end
        n_req = n_req + Q_ONE;
      end
    end
    q_overrun = (n_req > q_free);
  end

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    usage_d       = usage_q;
    q_pop         = 1'b0;
    stk_we        = 1'b0;
    chk_fault     = 1'b0;
    chk_cause     = CAUSE_MISMATCH;
    fault_valid_d = fault_valid_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;
`ifdef CFI_SS_WRAP_EN
    disc_d        = disc_q;
`endif
    if (state_q == S_CHECK && count_q != '0) begin
      q_pop = 1'b1;
      if (!q_ret_q[rptr_q]) begin
        if (usage_q != STK_FULL) begin
          stk_we  = 1'b1;
          sp_d    = sp_q + SP_ONE;
          usage_d = usage_q + SC_ONE;
        end else begin
`ifdef CFI_SS_WRAP_EN
          // Full circular stack: sp already points at the oldest entry.
          stk_we = 1'b1;
          sp_d   = sp_q + SP_ONE;
          if (disc_q != '1) disc_d = disc_q + SC_ONE;
`else
          chk_fault = 1'b1;
          chk_cause = CAUSE_OVERFLOW;
`endif
        end
      end else if (usage_q == '0) begin
`ifdef CFI_SS_WRAP_EN
        if (disc_q != '0) begin
          disc_d = disc_q - SC_ONE;
        end else begin
          chk_fault = 1'b1;
          chk_cause = CAUSE_UNDERFLOW;
        end
`else
        chk_fault = 1'b1;
        chk_cause = CAUSE_UNDERFLOW;
`endif
      end else begin
        chk_fault = (stack_top != q_tgt_q[rptr_q]);
        sp_d      = sp_q - SP_ONE;
        usage_d   = usage_q - SC_ONE;
      end
    end

    count_d = count_q + n_acc - QCW'(q_pop);
    wptr_d  = wptr_q + n_acc[QPW-1:0];
    rptr_d  = rptr_q + QPW'(q_pop);

    if (state_q == S_IDLE && count_q != '0) state_d = S_CHECK;
    if (state_q == S_CHECK)                 state_d = (count_d != '0) ? S_CHECK : S_IDLE;

    // A pending fault blocks all new reports; checker faults outrank overrun.
    if (fault_valid_q) begin
      if (fault_ack_i) begin
        fault_valid_d = 1'b0;
        state_d       = (count_d != '0) ? S_CHECK : S_IDLE;
      end
    end else if (chk_fault) begin
      fault_valid_d = 1'b1;
      fault_cause_d = chk_cause;
      fault_pc_d    = q_pc_q[rptr_q];
      state_d       = S_FAULT;
    end else if (q_overrun) begin
      fault_valid_d = 1'b1;
      fault_cause_d = CAUSE_OVERRUN;
      fault_pc_d    = '0;
      state_d       = S_FAULT;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_PORTS; p++) begin
      if (q_we[p]) begin
        q_ret_q[q_waddr[p]] <= log_kind_i[p][0];
        q_pc_q[q_waddr[p]]  <= log_pc_i[p];
        q_tgt_q[q_waddr[p]] <= log_target_i[p];
        q_rvc_q[q_waddr[p]] <= log_rvc_i[p];
      end
    end
    if (stk_we) stack_q[sp_q] <= ret_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      sp_q          <= '0;
      usage_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= 2'b00;
      fault_pc_q    <= '0;
`ifdef CFI_SS_WRAP_EN
      disc_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      sp_q          <= sp_d;
      usage_q       <= usage_d;
      fault_valid_q <= fault_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
`ifdef CFI_SS_WRAP_EN
      disc_q        <= disc_d;
`endif
    end
  end

  assign halt_o        = (count_q > Q_HALT);
  assign fault_valid_o = fault_valid_q;
  assign fault_cause_o = fault_cause_q;
  assign fault_pc_o    = fault_pc_q;
  assign stack_usage_o = usage_q;

endmodule
`default_nettype wire

// File: doc/cfi_shadow_stack_stage.md
# cfi_shadow_stack_stage

Parametrised successor CFI stage: it captures up to NR_PORTS committed control-flow events per cycle into an internal multi-write queue and drains them in order into a hardware shadow-stack checker. Calls push their return address. Returns are checked against the stack top. Mismatch, overflow, underflow and queue overrun raise a held fault until acknowledged. It sits beside the commit stage and drives the commit-halt request and the CFI fault report.

## Interface
- NR_PORTS, 2: commit ports sampled per cycle (1..4).
- QUEUE_DEPTH, 8: event queue entries (power of 2, >= 2*NR_PORTS).
- STACK_DEPTH, 16: shadow-stack entries (power of 2).
- XLEN, 64: address width.

- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- log_valid_i  in  NR_PORTS  committed (already acked) CFI event per port.
- log_kind_i  in  NR_PORTS x 2  00 branch, 01 jump, 10 call, 11 return.
- log_pc_i  in  NR_PORTS x XLEN  PC of the event instruction.
- log_target_i  in  NR_PORTS x XLEN  resolved target address.
- log_rvc_i  in  NR_PORTS  instruction is compressed.
- halt_o  out  1  commit must stall; free queue entries < NR_PORTS.
- fault_valid_o  out  1  fault pending.
- fault_cause_o  out  2  00 overrun, 01 mismatch, 10 overflow, 11 underflow.
- fault_pc_o  out  XLEN  PC of the offending event (0 for overrun).
- fault_ack_i  in  1  clears the pending fault.
- stack_usage_o  out  $clog2(STACK_DEPTH)+1  valid stack entries.

## Operation
- Filter:
  - Only valid call/return events are enqueued; branches and jumps are ignored.
  - Enqueued events are compacted in ascending port order, so port 0 precedes port 1.
- Queue:
  - Up to NR_PORTS writes and 1 read per cycle. No fall-through.
  - Push and pop may occur in the same cycle.
- Overrun:
  - If the enqueue count exceeds the free entries, the excess highest-port events are dropped.
  - Fault cause 00 is raised.
- Checker FSM:
  - IDLE: moves to CHECK when the queue is non-empty.
  - CHECK:
    - Pops one entry per cycle.
    - Call: pushes pc+4, or pc+2 when rvc.
    - Return: compares the stack top with target, then pops. Unequal sets cause 01.
    - Returns to IDLE when the queue is empty after the pop.
  - FAULT: entered on any fault. No queue pops while in FAULT.
    - On fault_ack_i, goes to CHECK if the queue is non-empty, else IDLE.
- Stack boundaries:
  - Return on an empty stack gives cause 11; the stack is unchanged.
  - Call on a full stack: see Configuration.
- Fault priority:
  - Fault registers are written only when no fault is pending.
  - The first fault wins.
  - Overrun arriving in the same cycle as a checker fault loses to the checker fault.
- Address arithmetic: modulo 2^XLEN; pc+4 wraps silently.

## Timing
- Reset values:
  - halt_o=0, fault_valid_o=0, fault_cause_o=0, fault_pc_o=0, stack_usage_o=0.
  - Queue empty, FSM in IDLE.
- halt_o:
  - Combinational from the registered queue count.
  - Asserts in the same cycle the count crosses QUEUE_DEPTH-NR_PORTS.
- Latency:
  - Event sampled at edge N is checked at edge N+1.
  - fault_valid_o is high after edge N+2.
  - The stack update is visible on stack_usage_o after edge N+2.
- Fault acknowledge:
  - fault_ack_i sampled high with fault_valid_o clears it at the next edge.
  - fault_ack_i is ignored when no fault is pending.
- Queue during FAULT: keeps accepting events; halt_o protects it.
- Reset mid-operation:
  - Queue, stack, wrap counter, FSM and fault state are all cleared at the next edge.
  - In-flight events are discarded.

## Configuration
- CFI_SS_WRAP_EN defined:
  - A call on a full stack overwrites the oldest entry (circular buffer) and increments a saturating discard counter, width $clog2(STACK_DEPTH)+1.
  - A return on an empty stack with a non-zero counter decrements the counter, skips the check, and raises no fault.
  - Cause 10 is never raised.
- CFI_SS_WRAP_EN undefined:
  - A call on a full stack raises cause 10 and is dropped; the stack is unchanged.
  - No discard counter is implemented.

## Test plan
- Matched call/return:
  - Stimulus: port0 call pc=0x8000_0000 rvc=0, then a return with target 0x8000_0004.
  - Response: no fault; stack_usage_o goes 0→1→0.
- Mismatch:
  - Stimulus: call pc=0x8000_0100 rvc=1, then a return with target 0x8000_0104.
  - Response: cause 01, fault_pc_o = return PC; stays held until fault_ack_i, then draining resumes.
- Same-cycle ordering:
  - Stimulus: NR_PORTS=2; port0 call pc=0x10, port1 return target 0x14 in the same cycle.
  - Response: no fault; stack_usage_o ends at 0.
- Overrun:
  - Stimulus: ignore halt_o; drive 2 calls/cycle for 5 cycles with QUEUE_DEPTH=8, with a fault held unacked.
  - Response: cause 00 is not overwritten, because the first fault wins.
  - Repeat with no prior fault: cause 00, fault_pc_o=0.
- Full stack:
  - Stimulus: 17 calls with STACK_DEPTH=16.
  - Response without the macro: cause 10 on the 17th call, stack_usage_o=16.
  - Response with CFI_SS_WRAP_EN: no fault, and 17 returns raise no underflow.
- Reset mid-drain:
  - Stimulus: assert rst_i with 4 queued events.
  - Response: all outputs are at their reset values after one edge.
